// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares the single program-ROM read port between the
// instruction-fetch path and the MOVC data-read path. Fetches assemble 1..3
// bytes from consecutive ROM addresses; MOVC reads a single byte. When both
// paths ask at once, a round-robin pointer picks the winner.
module rom_fetch_arbiter #(
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [ADDRWIDTH-1:0] fetch_pc,
    input  logic [1:0]           fetch_len,
    output logic                 fetch_ack,
    output logic [7:0]           fetch_op,
    output logic [7:0]           fetch_b1,
    output logic [7:0]           fetch_b2,
    output logic [ADDRWIDTH-1:0] fetch_next_pc,
    input  logic                 movc_req,
    input  logic [ADDRWIDTH-1:0] movc_addr,
    output logic                 movc_ack,
    output logic [7:0]           movc_data,
    output logic                 rom_cs_n,
    output logic [ADDRWIDTH-1:0] rom_addr,
    input  logic [7:0]           rom_dout,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACK
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   grant;
    logic                   grant_fetch;
    logic                   last_byte;

    logic                   prio_fetch;
    logic                   owner_fetch;
    logic [1:0]             len;
    logic [1:0]             idx;
    logic [ADDRWIDTH-1:0]   base_addr;
    logic [7:0]             byte0;
    logic [7:0]             byte1;

    // Next-state logic: grant from IDLE, finish READ on the last byte, ACK lasts one cycle
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_fetch = 1'b0;
        last_byte   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || movc_req) begin
                    grant       = 1'b1;
                    grant_fetch = fetch_req && (!movc_req || prio_fetch);
                    state_next  = READ;
                end
            end
            READ: begin
                if (idx == (len - 2'd1)) begin
                    last_byte  = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction setup at grant and ROM address stepping while bytes are read
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs_n    <= 1'b1;
            rom_addr    <= '0;
            idx         <= 2'd0;
            len         <= 2'd1;
            owner_fetch <= 1'b1;
            base_addr   <= '0;
            prio_fetch  <= 1'b1;
        end else if (grant) begin
            owner_fetch <= grant_fetch;
            prio_fetch  <= !grant_fetch;
            idx         <= 2'd0;
            rom_cs_n    <= 1'b0;
            if (grant_fetch) begin
                base_addr <= fetch_pc;
                rom_addr  <= fetch_pc;
                len       <= (fetch_len == 2'd0) ? 2'd1 : fetch_len;
            end else begin
                base_addr <= movc_addr;
                rom_addr  <= movc_addr;
                len       <= 2'd1;
            end
        end else if (state == READ) begin
            if (last_byte) begin
                rom_cs_n <= 1'b1;
            end else begin
                idx      <= idx + 2'd1;
                rom_addr <= rom_addr + ADDRWIDTH'(1);
            end
        end
    end

    // Byte capture, result assembly and one-cycle acknowledge to the owner
    always_ff @(posedge clk) begin
        if (rst) begin
            byte0         <= 8'h00;
            byte1         <= 8'h00;
            fetch_ack     <= 1'b0;
            fetch_op      <= 8'h00;
            fetch_b1      <= 8'h00;
            fetch_b2      <= 8'h00;
            fetch_next_pc <= '0;
            movc_ack      <= 1'b0;
            movc_data     <= 8'h00;
        end else begin
            fetch_ack <= 1'b0;
            movc_ack  <= 1'b0;
            if (state == READ) begin
                if (!last_byte) begin
                    if (idx == 2'd0) begin
                        byte0 <= rom_dout;
                    end else begin
                        byte1 <= rom_dout;
                    end
                end else if (owner_fetch) begin
                    fetch_ack     <= 1'b1;
                    fetch_op      <= (idx == 2'd0) ? rom_dout : byte0;
                    fetch_b1      <= (idx == 2'd1) ? rom_dout :
                                     (idx == 2'd2) ? byte1 : 8'h00;
                    fetch_b2      <= (idx == 2'd2) ? rom_dout : 8'h00;
                    fetch_next_pc <= base_addr + ADDRWIDTH'(len);
                end else begin
                    movc_ack  <= 1'b1;
                    movc_data <= rom_dout;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
